uart_tx_ctrl: RTL and testbench

UART transmit controller that accepts bytes over a valid/ready handshake and sequences them onto the serial line. It owns a one-entry holding register in front of the frame shifter, generates the bit-rate timing, and frames each character. Each frame is a start bit, 7 or 8 data bits LSB first, an optional parity bit, and one stop bit. It sits between the host-side write path and the `tx` pin of the UART.

---
 rtl/uart_tx_ctrl_if.sv | 19 +
 rtl/uart_tx_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake for the UART transmit controller.
// The host drives valid/data; the controller answers with ready.
interface uart_tx_ctrl_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one-entry holding register, bit timer and
// frame sequencer (start, 7/8 data bits LSB first, optional parity, stop).
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           data_length,
  input  logic           parity_en,
  input  logic           parity_odd,
  uart_tx_ctrl_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          len8_q, len8_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          accept_s;
  logic          bit_end_s;
  logic          load_s;
  logic [7:0]    load_data_s;
  logic [2:0]    last_bit_s;
  logic [7:0]    masked_s;

  // In 7-bit mode bit 7 is forced to zero so it never reaches the line or parity.
  function automatic logic [7:0] mask_data(input logic [7:0] d, input logic len8);
    logic [7:0] m;
    m = len8 ? d : {1'b0, d[6:0]};
    return m;
  endfunction

  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign accept_s     = bus.tx_valid & ready_q;
  assign bit_end_s    = (timer_q == TIMER_MAX);
  assign last_bit_s   = len8_q ? 3'd7 : 3'd6;
  assign bus.tx_ready = ready_q;
  assign tx           = tx_q;
  assign busy         = busy_q;

  // Next-state, holding-register and shifter logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    len8_d      = len8_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    load_s      = 1'b0;
    load_data_s = 8'h00;
    masked_s    = 8'h00;

    if (accept_s && (state_q != IDLE)) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end

    case (state_q)
      IDLE: begin
        timer_d = {TW{1'b0}};
        if (accept_s) begin
          load_s      = 1'b1;
          load_data_s = bus.tx_data;
        end else begin
          load_s = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d   = DATA;
          timer_d   = {TW{1'b0}};
          bit_cnt_d = 3'd0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          timer_d = {TW{1'b0}};
          if (bit_cnt_q == last_bit_s) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
          timer_d = {TW{1'b0}};
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (hold_full_q) begin
            load_s      = 1'b1;
            load_data_s = hold_q;
            hold_full_d = 1'b0;
          end else if (accept_s) begin
            // Byte arriving on the very last stop edge goes straight to the shifter.
            load_s      = 1'b1;
            load_data_s = bus.tx_data;
            hold_d      = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = IDLE;
            timer_d = {TW{1'b0}};
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = {TW{1'b0}};
      end
    endcase

    // Framing options are captured together with the data so mid-frame changes are ignored.
    if (load_s) begin
      masked_s  = mask_data(load_data_s, data_length);
      shift_d   = masked_s;
      len8_d    = data_length;
      par_en_d  = parity_en;
      par_bit_d = parity_of(masked_s, parity_odd);
      timer_d   = {TW{1'b0}};
      bit_cnt_d = 3'd0;
      state_d   = START;
    end else begin
      masked_s = 8'h00;
    end
  end

  // Registered line level, ready and busy derived from the next state.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = ~hold_full_d;
    busy_d  = (state_d != IDLE) | hold_full_d;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with asynchronous abort.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      timer_q     <= {TW{1'b0}};
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      len8_q      <= 1'b0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      len8_q      <= len8_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: expected frames are queued at accept
// time and compared cycle by cycle against the serial line.
module tb_uart_tx_ctrl;
  localparam int CPB = 4;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
  } frame_t;

  logic clk;
  logic arst_n;
  logic data_length;
  logic parity_en;
  logic parity_odd;
  logic tx;
  logic busy;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .data_length (data_length),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .bus         (bus),
    .tx          (tx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  frame_t exp_q[$];
  int     starts_q[$];
  frame_t cur;
  bit     in_frame = 1'b0;
  int     pos = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic len8,
                                        input logic pen, input logic podd);
    frame_t f;
    int     n;
    int     idx;
    logic   p;
    n      = len8 ? 8 : 7;
    f.bits = '1;
    f.bits[0] = 1'b0;
    p = podd;
    for (int i = 0; i < n; i++) begin
      f.bits[1 + i] = d[i];
      p = p ^ d[i];
    end
    idx = 1 + n;
    if (pen) begin
      f.bits[idx] = p;
      idx++;
    end
    f.bits[idx] = 1'b1;
    f.nbits = idx + 1;
    return f;
  endfunction

  // Advance to the next falling edge and score the line against the expected frame.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!arst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          pos      = 0;
          starts_q.push_back(cyc);
        end
      end
      if (in_frame) begin
        chk($sformatf("line_bit%0d", pos / CPB), 32'(tx), 32'(cur.bits[pos / CPB]));
        pos++;
        if (pos == cur.nbits * CPB) in_frame = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, output int acc_cyc);
    int   n;
    bit   done;
    logic ready_s;
    n = 0;
    done = 1'b0;
    acc_cyc = -1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    while (!done && n < 200) begin
      ready_s = bus.tx_ready;
      if (ready_s === 1'b1) exp_q.push_back(make_frame(d, data_length, parity_en, parity_odd));
      tick();
      n++;
      if (ready_s === 1'b1) begin
        done = 1'b1;
        acc_cyc = cyc;
      end
    end
    bus.tx_valid = 1'b0;
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || in_frame) && n < 400) begin
      n++;
      tick();
    end
    chk("drain_timeout", 32'(n < 400), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc0;
    int acc1;
    int acc2;
    int n;
    int lows;

    // Reset with random inputs
    arst_n       = 1'b0;
    bus.tx_valid = 1'($urandom_range(1, 0));
    bus.tx_data  = 8'($urandom);
    data_length  = 1'($urandom_range(1, 0));
    parity_en    = 1'($urandom_range(1, 0));
    parity_odd   = 1'($urandom_range(1, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(bus.tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      bus.tx_data = 8'($urandom);
    end
    bus.tx_valid = 1'b0;
    data_length  = 1'b1;
    parity_en    = 1'b0;
    parity_odd   = 1'b0;
    arst_n       = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_tx", 32'(tx), 32'd1);
    end

    // 8-bit frame, no parity
    send(8'hA5, acc0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("busy_len_8n", 32'(n), 32'd40);
    wait_idle();

    // 7-bit frame, even parity
    data_length = 1'b0;
    parity_en   = 1'b1;
    parity_odd  = 1'b0;
    send(8'hFF, acc0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("busy_len_7e", 32'(n), 32'd40);
    wait_idle();

    // Odd parity, 8 bits
    data_length = 1'b1;
    parity_odd  = 1'b1;
    send(8'h3C, acc0);
    wait_idle();

    // Back-to-back frames through the holding register
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    starts_q.delete();
    send(8'h55, acc0);
    for (int i = 0; i < 4; i++) tick();
    send(8'h0F, acc1);
    chk("b2b_second_accept", 32'(acc1 - acc0), 32'd5);
    chk("b2b_ready_low", 32'(bus.tx_ready), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    send(8'h33, acc2);
    chk("b2b_third_accept", 32'(acc2 - acc0), 32'd41);
    wait_idle();
    chk("b2b_start_count", 32'(starts_q.size()), 32'd3);
    if (starts_q.size() == 3) begin
      chk("b2b_gap1", 32'(starts_q[1] - starts_q[0]), 32'd40);
      chk("b2b_gap2", 32'(starts_q[2] - starts_q[1]), 32'd40);
    end

    // Mid-frame config change is ignored
    data_length = 1'b1;
    send(8'h80, acc0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 12) data_length = 1'b0;
      n++;
      tick();
    end
    chk("cfg_hold_len", 32'(n), 32'd40);
    wait_idle();
    send(8'h80, acc0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("cfg_next_len", 32'(n), 32'd36);
    wait_idle();

    // Asynchronous reset mid-frame with a byte held
    data_length = 1'b1;
    send(8'hC3, acc0);
    send(8'h3C, acc1);
    chk("abort_held", 32'(bus.tx_ready), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("pre_reset_tx", 32'(tx), 32'd0);
    #1 arst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_ready", 32'(bus.tx_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) tick();
    arst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    chk("no_stale_frame", 32'(lows), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Recovery after reset
    send(8'h5A, acc0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
